keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner_if.sv | 12 +
 rtl/keypad_scanner.sv | 164 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad bundle: active-low row sense lines, active-low column drive and the decoded key outputs.
// The scanner uses the master modport; the keypad side (or a bench) uses the slave modport.
interface keypad_scanner_if;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key;
   logic       key_valid;
   logic       key_down;

   modport master (input row, output col, key, key_valid, key_down);
   modport slave  (output row, input col, key, key_valid, key_down);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks one low column per scan tick, debounces press and release, reports key codes.
// Optional auto-repeat of a held key is compiled in when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
   parameter int TICK_DIV       = 100000,
   parameter int DEBOUNCE_TICKS = 20
) (
   input logic               clk,
   input logic               rst,
   keypad_scanner_if.master  kp
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   state_t          state, state_nx;
   logic [3:0]      row_meta, row_s;
   logic [TW-1:0]   tick_cnt;
   logic            tick;
   logic [1:0]      col_idx, col_idx_nx;
   logic [3:0]      cand, cand_nx;
   logic [3:0]      key_r, key_nx;
   logic            key_valid_r, valid_nx;
   logic [DW-1:0]   deb_cnt, deb_nx;
   logic            low_found;
   logic [1:0]      low_idx;
`ifdef KEYPAD_REPEAT_EN
   logic [8:0]      rep_cnt, rep_nx;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         row_meta <= 4'hF;
         row_s    <= 4'hF;
      end else begin
         row_meta <= kp.row;
         row_s    <= row_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || tick) tick_cnt <= '0;
      else             tick_cnt <= tick_cnt + TW'(1);
   end

   assign tick = (tick_cnt == TW'(TICK_DIV - 1));

   // Lowest-indexed low row wins when several rows are pressed together.
   always_comb begin
      low_found = 1'b0;
      low_idx   = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!row_s[i]) begin
            low_found = 1'b1;
            low_idx   = 2'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= SCAN;
         col_idx     <= 2'd0;
         cand        <= 4'h0;
         key_r       <= 4'h0;
         key_valid_r <= 1'b0;
         deb_cnt     <= '0;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt     <= 9'd0;
`endif
      end else begin
         state       <= state_nx;
         col_idx     <= col_idx_nx;
         cand        <= cand_nx;
         key_r       <= key_nx;
         key_valid_r <= valid_nx;
         deb_cnt     <= deb_nx;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt     <= rep_nx;
`endif
      end
   end

   // Debounce counters count confirming ticks after the first one, hence the DEBOUNCE_TICKS-2 limit.
   always_comb begin
      state_nx   = state;
      col_idx_nx = col_idx;
      cand_nx    = cand;
      key_nx     = key_r;
      valid_nx   = 1'b0;
      deb_nx     = deb_cnt;
`ifdef KEYPAD_REPEAT_EN
      rep_nx     = rep_cnt;
`endif
      if (tick) begin
         case (state)
            SCAN: begin
               if (!low_found) begin
                  col_idx_nx = col_idx + 2'd1;
               end else begin
                  cand_nx  = {low_idx, col_idx};
                  deb_nx   = '0;
                  state_nx = DEBOUNCE;
               end
            end
            DEBOUNCE: begin
               if (low_found && (low_idx == cand[3:2])) begin
                  if (deb_cnt == DW'(DEBOUNCE_TICKS - 2)) begin
                     key_nx   = cand;
                     valid_nx = 1'b1;
                     state_nx = HELD;
`ifdef KEYPAD_REPEAT_EN
                     rep_nx   = 9'd0;
`endif
                  end else begin
                     deb_nx = deb_cnt + DW'(1);
                  end
               end else begin
                  state_nx = SCAN;
               end
            end
            HELD: begin
               if (!low_found) begin
                  deb_nx   = '0;
                  state_nx = RELEASE;
               end else begin
`ifdef KEYPAD_REPEAT_EN
                  // First repeat after 500 held ticks, then reload so the next comes 100 ticks later.
                  if (rep_cnt == 9'd499) begin
                     valid_nx = 1'b1;
                     rep_nx   = 9'd400;
                  end else begin
                     rep_nx = rep_cnt + 9'd1;
                  end
`endif
               end
            end
            RELEASE: begin
               if (!low_found) begin
                  if (deb_cnt == DW'(DEBOUNCE_TICKS - 2)) begin
                     state_nx   = SCAN;
                     col_idx_nx = col_idx + 2'd1;
                  end else begin
                     deb_nx = deb_cnt + DW'(1);
                  end
               end else begin
                  state_nx = HELD;
`ifdef KEYPAD_REPEAT_EN
                  rep_nx   = 9'd0;
`endif
               end
            end
            default: state_nx = SCAN;
         endcase
      end
   end

   assign kp.col       = ~(4'b0001 << col_idx);
   assign kp.key       = key_r;
   assign kp.key_valid = key_valid_r;
   assign kp.key_down  = (state == HELD) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: tick-level reference model compared every cycle,
// directed keypad scenarios with literal expectations, then randomized row activity.
module tb_keypad_scanner;

   localparam int TD = 4;
   localparam int DB = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   keypad_scanner_if kp();

   keypad_scanner #(.TICK_DIV(TD), .DEBOUNCE_TICKS(DB)) dut (
      .clk (clk),
      .rst (rst),
      .kp  (kp)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int dut_pulses = 0;

   // Reference model: mode 0 scanning, 1 confirming a press, 2 held, 3 confirming a release.
   int         m_cyc, m_mode, m_cidx, m_cand, m_stable, m_held;
   logic [3:0] m_key;
   bit         m_valid;
   logic [3:0] m_s1, m_s2;

   logic [3:0] col_seq [5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};

   function automatic int lowest_low(input logic [3:0] r);
      for (int i = 0; i < 4; i++) if (r[i] == 1'b0) return i;
      return -1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] r, input int ticks);
      kp.row = r;
      repeat (ticks * TD) @(negedge clk);
   endtask

   task automatic waitAlign(input int target);
      int budget = 0;
      while (!(m_mode == 0 && m_cyc > 0 && (m_cyc % TD) == 0 && (target < 0 || m_cidx == target))) begin
         @(negedge clk);
         budget++;
         if (budget > 200) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL align_timeout: got no scan alignment, expected one within 200 cycles");
            return;
         end
      end
   endtask

   always @(posedge clk) begin
      int low;
      bit tk;
      if (rst) begin
         m_cyc = 0; m_mode = 0; m_cidx = 0; m_cand = 0;
         m_stable = 0; m_held = 0; m_key = 4'h0; m_valid = 0;
         m_s1 = 4'hF; m_s2 = 4'hF;
      end else begin
         tk   = (m_cyc % TD) == TD - 1;
         low  = lowest_low(m_s2);
         m_s2 = m_s1;
         m_s1 = kp.row;
         m_valid = 0;
         if (tk) begin
            case (m_mode)
               0: if (low < 0) m_cidx = (m_cidx + 1) % 4;
                  else begin m_cand = low * 4 + m_cidx; m_stable = 1; m_mode = 1; end
               1: if (low >= 0 && low == m_cand / 4) begin
                     m_stable++;
                     if (m_stable == DB) begin
                        m_key = 4'(m_cand); m_valid = 1; m_mode = 2; m_held = 0;
                     end
                  end else m_mode = 0;
               2: if (low < 0) begin m_stable = 1; m_mode = 3; end
                  else begin
                     m_held++;
`ifdef KEYPAD_REPEAT_EN
                     if (m_held >= 500 && (m_held - 500) % 100 == 0) m_valid = 1;
`endif
                  end
               default: if (low < 0) begin
                     m_stable++;
                     if (m_stable == DB) begin m_mode = 0; m_cidx = (m_cidx + 1) % 4; end
                  end else begin m_mode = 2; m_held = 0; end
            endcase
         end
         m_cyc++;
      end
   end

   // Every active cycle the DUT outputs must equal the model's view.
   always @(negedge clk) begin
      logic [3:0] ecol;
      if (!rst) begin
         ecol = ~(4'b0001 << m_cidx);
         checkOutput("col", kp.col, ecol);
         checkOutput("key", kp.key, m_key);
         checkOutput("key_valid", kp.key_valid, m_valid);
         checkOutput("key_down", kp.key_down, (m_mode == 2 || m_mode == 3));
         if (kp.key_valid === 1'b1) dut_pulses++;
      end
   end

   initial begin
      int p0;
      int exp_long;
      kp.row = 4'hF;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_col", kp.col, 4'hE);
      checkOutput("reset_key", kp.key, 4'h0);
      checkOutput("reset_valid", kp.key_valid, 1'b0);
      checkOutput("reset_down", kp.key_down, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         checkOutput("scan_col_seq", kp.col, col_seq[i]);
         repeat (TD) @(negedge clk);
      end
      checkOutput("idle_no_pulse", dut_pulses, 0);

      // Row 1 pressed under column 2 decodes to key 6.
      waitAlign(2);
      p0 = dut_pulses;
      applyStimulus(4'b1101, 6);
      checkOutput("press_key6", kp.key, 4'h6);
      checkOutput("press_down", kp.key_down, 1'b1);
      checkOutput("press_col_held", kp.col, 4'hB);
      checkOutput("press_one_pulse", dut_pulses - p0, 1);
      applyStimulus(4'hF, 5);
      checkOutput("release_down", kp.key_down, 1'b0);
      checkOutput("release_key_kept", kp.key, 4'h6);

      // One-tick press is a bounce.
      waitAlign(-1);
      p0 = dut_pulses;
      applyStimulus(4'b1110, 1);
      applyStimulus(4'hF, 3);
      checkOutput("bounce_no_pulse", dut_pulses - p0, 0);
      checkOutput("bounce_key_kept", kp.key, 4'h6);

      // Release with a one-tick re-press glitch.
      waitAlign(-1);
      p0 = dut_pulses;
      applyStimulus(4'b1011, 5);
      applyStimulus(4'hF, 1);
      applyStimulus(4'b1011, 1);
      applyStimulus(4'hF, 1);
      checkOutput("glitch_still_down", kp.key_down, 1'b1);
      applyStimulus(4'hF, 3);
      checkOutput("glitch_down_fell", kp.key_down, 1'b0);
      checkOutput("glitch_one_pulse", dut_pulses - p0, 1);

      // Rows 1 and 3 together under column 0: row 1 wins.
      waitAlign(0);
      applyStimulus(4'b0101, 5);
      checkOutput("multi_row_key4", kp.key, 4'h4);
      applyStimulus(4'hF, 4);

      // Reset mid-debounce aborts without a pulse.
      waitAlign(-1);
      p0 = dut_pulses;
      kp.row = 4'b0111;
      repeat (2 * TD) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("abort_key", kp.key, 4'h0);
      checkOutput("abort_valid", kp.key_valid, 1'b0);
      checkOutput("abort_down", kp.key_down, 1'b0);
      rst = 1'b0;
      applyStimulus(4'hF, 3);
      checkOutput("abort_no_pulse", dut_pulses - p0, 0);

      // Long hold: repeats only when auto-repeat is built in.
`ifdef KEYPAD_REPEAT_EN
      exp_long = 3;
`else
      exp_long = 1;
`endif
      waitAlign(-1);
      p0 = dut_pulses;
      applyStimulus(4'b1110, 610);
      checkOutput("long_hold_down", kp.key_down, 1'b1);
      checkOutput("long_hold_pulses", dut_pulses - p0, exp_long);
      applyStimulus(4'hF, 4);

      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, TD - 1)) @(negedge clk);
         if ($urandom_range(0, 2) == 0) applyStimulus(4'hF, int'($urandom_range(1, 6)));
         else applyStimulus(4'($urandom_range(0, 15)), int'($urandom_range(1, 7)));
      end
      applyStimulus(4'hF, 6);
      checkOutput("final_down", kp.key_down, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
